cpu_run_monitor: RTL
====================

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter REG_NUM, default 32, register-file entries dumped.
REQ-003 Parameter ADDR_SIZE, default 5, register address width.
REQ-004 Parameter PC_BITS, default 5, fetch PC width.
REQ-005 Parameter END_PC, default 22, lowest PC at which a NOP ends the run.
REQ-006 Parameter DRAIN_CYCLES, default 5, cycles waited after end detection.
REQ-007 Parameter TIMEOUT, default 2000, run-cycle limit.
REQ-008 Parameter CNT_W, default 16, width of all counters.
REQ-009 clk  in  1  single clock; all state changes on its rising edge.
REQ-010 rst  in  1  reset, synchronous, active-low.
REQ-011 start  in  1  one-cycle pulse that begins a run.
REQ-012 f_pc  in  PC_BITS  fetch-stage PC; f_inst  in  32  fetch-stage instruction.
REQ-013 ex_taken  in  1  EX branch taken; stall_d  in  1  decode stall.
REQ-014 rf_raddr  out  ADDR_SIZE  register-file read address; rf_rdata  in  XLEN  asynchronous read data.
REQ-015 dump_valid  out  1; dump_ready  in  1; dump_idx  out  ADDR_SIZE; dump_data  out  XLEN  register dump stream.
REQ-016 busy, done, timeout  out  1 each  status flags.
REQ-017 cycles, taken_cnt, stall_cnt  out  CNT_W each  run statistics.

Function
REQ-018 FSM states: IDLE, RUN, DRAIN, DUMP_LD, DUMP_OUT, DONE.
REQ-019 IDLE or DONE with start=1 -> RUN next cycle; entry clears cycles, taken_cnt, stall_cnt, timeout, done, and sets dump_idx=0.
REQ-020 start is ignored in RUN, DRAIN, DUMP_LD and DUMP_OUT.
REQ-021 RUN: cycles increments by 1 each cycle, saturating at 2^CNT_W-1.
REQ-022 RUN: end condition is f_pc >= END_PC (unsigned) and f_inst == 0; when true -> DRAIN; cycles keeps the value it had in that cycle.
REQ-023 RUN: when cycles == TIMEOUT and the end condition is false -> set timeout=1 and go straight to DUMP_LD, with no drain.
REQ-024 End condition and timeout in the same cycle: end wins; timeout stays 0.
REQ-025 DRAIN: waits exactly DRAIN_CYCLES cycles, then -> DUMP_LD; with DRAIN_CYCLES=0, DRAIN lasts one cycle.
REQ-026 DUMP_LD: drives rf_raddr=dump_idx, captures rf_rdata into dump_data, then -> DUMP_OUT.
REQ-027 DUMP_OUT: dump_valid=1; dump_idx and dump_data stay stable until dump_ready=1.
REQ-028 DUMP_OUT handshake (dump_valid & dump_ready):
  - dump_idx < REG_NUM-1: increment dump_idx, -> DUMP_LD.
  - dump_idx == REG_NUM-1: -> DONE.
REQ-029 Throughput: at most one dump record every 2 cycles.
REQ-030 DONE: done=1, dump_valid=0, all counters hold.
REQ-031 busy=1 in RUN, DRAIN, DUMP_LD and DUMP_OUT; 0 otherwise.
REQ-032 rf_raddr equals dump_idx in all states.

Reset
REQ-033 rst=0 at a clock edge: state=IDLE; every output 0 (busy, done, timeout, dump_valid, dump_idx, dump_data, rf_raddr, all counters).
REQ-034 Reset mid-run or mid-dump aborts immediately; no partial record is presented afterwards.

Configuration
REQ-035 Macro RUN_MON_STATS_EN defined: in RUN only, taken_cnt counts cycles with ex_taken=1 and stall_cnt counts cycles with stall_d=1, both saturating.
REQ-036 Macro RUN_MON_STATS_EN undefined: taken_cnt and stall_cnt are constant 0 and their counter logic is absent; cycles is unaffected.

Structure
REQ-037 Shared package cpu_run_pkg holds the FSM state type and the defaults for END_PC, DRAIN_CYCLES and TIMEOUT.
REQ-038 Sub-module run_sat_counter (CNT_W wide, clear, enable, saturate) is instantiated for cycles, taken_cnt and stall_cnt.

Verification
REQ-039 start, then f_pc 0..22 with f_inst nonzero below 22 and 0 at 22 -> DRAIN for 5 cycles; cycles=23, timeout=0; then 32 records idx 0..31; done=1.
REQ-040 TIMEOUT=10, f_inst never 0 -> timeout=1, cycles=10, no drain, dump follows.
REQ-041 f_inst=0 at f_pc=5 -> no end (5 < 22); at f_pc=22 with cycles==TIMEOUT -> end wins, timeout=0.
REQ-042 dump_ready low 3 cycles per record -> idx/data stable during wait; regs preloaded with i*3 give dump_data=i*3 in order.
REQ-043 rst=0 during DUMP_OUT at idx 7 -> next cycle all outputs 0; a new start restarts the dump at idx 0.
REQ-044 With RUN_MON_STATS_EN, 4 ex_taken cycles and 6 stall_d cycles in RUN -> taken_cnt=4, stall_cnt=6; without the macro both read 0.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared types and parameter defaults for the CPU run monitor.
package cpu_run_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DUMP_LD,
        DUMP_OUT,
        DONE
    } run_state_e;

    localparam int END_PC_DEF       = 22;
    localparam int DRAIN_CYCLES_DEF = 5;
    localparam int TIMEOUT_DEF      = 2000;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Register-file read port plus register dump stream of the run monitor.
interface cpu_run_monitor_if #(
    parameter int XLEN      = 32,
    parameter int ADDR_SIZE = 5
);
    logic [ADDR_SIZE-1:0] rf_raddr;
    logic [XLEN-1:0]      rf_rdata;
    logic                 dump_valid;
    logic                 dump_ready;
    logic [ADDR_SIZE-1:0] dump_idx;
    logic [XLEN-1:0]      dump_data;

    modport master (
        output rf_raddr, dump_valid, dump_idx, dump_data,
        input  rf_rdata, dump_ready
    );

    modport slave (
        input  rf_raddr, dump_valid, dump_idx, dump_data,
        output rf_rdata, dump_ready
    );
endinterface

// File: rtl/run_sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
module run_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/cpu_run_monitor.sv
// Watches a CPU run to its end-of-program NOP or timeout, then dumps the register file.
// Optional per-run branch/stall statistics are enabled with `define RUN_MON_STATS_EN.
module cpu_run_monitor
    import cpu_run_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int REG_NUM      = 32,
    parameter int ADDR_SIZE    = 5,
    parameter int PC_BITS      = 5,
    parameter int END_PC       = END_PC_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PC_BITS-1:0]  f_pc,
    input  logic [31:0]         f_inst,
    input  logic                ex_taken,
    input  logic                stall_d,
    cpu_run_monitor_if.master   bus,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [CNT_W-1:0]    cycles,
    output logic [CNT_W-1:0]    taken_cnt,
    output logic [CNT_W-1:0]    stall_cnt
);
    localparam int                   DRW        = $clog2(DRAIN_CYCLES + 1) + 1;
    localparam logic [DRW-1:0]       DRAIN_LAST = DRW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
    localparam logic [ADDR_SIZE-1:0] LAST_IDX   = ADDR_SIZE'(REG_NUM - 1);

    run_state_e           r_state;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_timeout;
    logic                 r_dump_valid;
    logic [ADDR_SIZE-1:0] r_dump_idx;
    logic [XLEN-1:0]      r_dump_data;
    logic [DRW-1:0]       r_drain_cnt;

    logic                 w_run;
    logic                 w_end;
    logic                 w_tmo_hit;
    logic                 w_start_go;
    logic [CNT_W-1:0]     w_cycles;

    assign w_run      = (r_state == RUN);
    assign w_end      = (32'(f_pc) >= 32'(END_PC)) && (f_inst == '0);
    // End detection has priority, so a simultaneous timeout is suppressed here.
    assign w_tmo_hit  = w_run && !w_end && (w_cycles == CNT_W'(TIMEOUT));
    assign w_start_go = start && ((r_state == IDLE) || (r_state == DONE));

    run_sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start_go),
        .i_en  (w_run && !w_tmo_hit),
        .o_q   (w_cycles)
    );

`ifdef RUN_MON_STATS_EN
    run_sat_counter #(.W(CNT_W)) u_taken (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start_go),
        .i_en  (w_run && ex_taken),
        .o_q   (taken_cnt)
    );

    run_sat_counter #(.W(CNT_W)) u_stall (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_start_go),
        .i_en  (w_run && stall_d),
        .o_q   (stall_cnt)
    );
`else
    logic w_unused_stats;
    assign w_unused_stats = ex_taken ^ stall_d;
    assign taken_cnt      = '0;
    assign stall_cnt      = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_idx   <= '0;
            r_dump_data  <= '0;
            r_drain_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= RUN;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_dump_idx <= '0;
                    end
                end
                RUN: begin
                    if (w_end) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= '0;
                    end else if (w_tmo_hit) begin
                        r_state   <= DUMP_LD;
                        r_timeout <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= DUMP_LD;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                DUMP_LD: begin
                    r_dump_data  <= bus.rf_rdata;
                    r_dump_valid <= 1'b1;
                    r_state      <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (bus.dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (r_dump_idx == LAST_IDX) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_dump_idx <= r_dump_idx + 1'b1;
                            r_state    <= DUMP_LD;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.rf_raddr   = r_dump_idx;
    assign bus.dump_idx   = r_dump_idx;
    assign bus.dump_valid = r_dump_valid;
    assign bus.dump_data  = r_dump_data;
    assign busy           = r_busy;
    assign done           = r_done;
    assign timeout        = r_timeout;
    assign cycles         = w_cycles;
endmodule
